// File: rtl/fft_seq_pkg.sv
// Shared constants and types for the 32-point radix-4 MDC frame sequencer.
// Ages count cycles since the accepting cycle (age 0).
package fft_seq_pkg;
  localparam int FRAME_LEN = 8;
  localparam int NUM_STG   = 5;
  localparam int AGE_W     = 6;
  localparam int TAGW      = 3;
  localparam int CNT_W     = 3;
  localparam int COOL_W    = $clog2(FRAME_LEN);
  localparam int OUT_OFS   = 30;
  localparam int RET       = OUT_OFS + FRAME_LEN - 1;

  typedef logic [AGE_W-1:0] age_t;
  typedef logic [TAGW-1:0]  tag_t;

  localparam age_t OUT_AGE = age_t'(OUT_OFS);
  localparam age_t RET_AGE = age_t'(RET);
  localparam logic [NUM_STG-1:0][AGE_W-1:0] OFS = {6'd26, 6'd21, 6'd17, 6'd7, 6'd3};

  typedef enum logic {SLOT_FREE = 1'b0, SLOT_RUN = 1'b1} slot_st_e;

  typedef struct packed {
    logic [NUM_STG-1:0] stg;
    logic               ov;
    logic               first;
    logic               last;
    tag_t               tag;
  } slot_out_t;
endpackage

// File: rtl/fft_frame_sequencer_slot.sv
// One in-flight frame: active flag, age counter and tag, with decoded stage
// start matches and output-window flags.
module frame_slot
  import fft_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      alloc,
  input  logic      clr,
  input  tag_t      tag_in,
  output logic      active,
  output logic      retire,
  output slot_out_t so
);
  slot_st_e st_q, st_d;
  age_t     age_q, age_d;
  tag_t     tag_q, tag_d;

  always_comb begin
    st_d  = st_q;
    age_d = age_q;
    tag_d = tag_q;
    if (clr) begin
      st_d  = SLOT_FREE;
      age_d = '0;
    end else if (alloc) begin
      // accepting cycle is age 0, so the first registered age is 1
      st_d  = SLOT_RUN;
      age_d = age_t'(1);
      tag_d = tag_in;
    end else if (st_q == SLOT_RUN) begin
      if (age_q == RET_AGE) begin
        st_d  = SLOT_FREE;
        age_d = '0;
      end else begin
        age_d = age_q + age_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= SLOT_FREE;
      age_q <= '0;
      tag_q <= '0;
    end else begin
      st_q  <= st_d;
      age_q <= age_d;
      tag_q <= tag_d;
    end
  end

  assign active = (st_q == SLOT_RUN);
  assign retire = active && (age_q == RET_AGE);

  always_comb begin
    so = '0;
    for (int k = 0; k < NUM_STG; k++) so.stg[k] = active && (age_q == OFS[k]);
    so.ov    = active && (age_q >= OUT_AGE) && (age_q <= RET_AGE);
    so.first = active && (age_q == OUT_AGE);
    so.last  = retire;
    so.tag   = so.ov ? tag_q : '0;
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// Multi-frame scheduler: accepts frame starts, allocates a slot per frame,
// enforces FRAME_LEN spacing and ORs slot outputs into stage pulses and the output window.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int MAX_INFLIGHT = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  input  tag_t               IN_TAG,
  output logic               IN_READY,
  input  logic               SOFT_CLR,
  output logic [NUM_STG-1:0] STG_START,
  output logic               OUT_VALID,
  output logic               OUT_FIRST,
  output logic               OUT_LAST,
  output tag_t               OUT_TAG,
  output logic [CNT_W-1:0]   INFLIGHT,
  output logic               BUSY
);
  if (RET >= (1 << AGE_W) - 1) begin : g_bad_ret
    $error("frame age would wrap before retire");
  end
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT >= (1 << CNT_W)) begin : g_bad_slots
    $error("MAX_INFLIGHT does not fit the INFLIGHT count");
  end

  logic [MAX_INFLIGHT-1:0] act, ret, alloc;
  slot_out_t [MAX_INFLIGHT-1:0] so;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic rdy_en_q, rdy_en_d;
  logic [CNT_W-1:0] n_act, n_ret;
  logic accept, found;
  logic [NUM_STG-1:0] stg_multi;

  for (genvar i = 0; i < MAX_INFLIGHT; i++) begin : g_slot
    frame_slot u_slot (
      .clk    (CLK),
      .rst_n  (RST),
      .alloc  (alloc[i]),
      .clr    (SOFT_CLR),
      .tag_in (IN_TAG),
      .active (act[i]),
      .retire (ret[i]),
      .so     (so[i])
    );
  end

  always_comb begin
    n_act = '0;
    n_ret = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      n_act = n_act + CNT_W'(act[i]);
      n_ret = n_ret + CNT_W'(ret[i]);
    end
    // a retiring slot frees its place in the same cycle
    IN_READY = rdy_en_q && !SOFT_CLR && (cool_q == '0) &&
               ((n_act - n_ret) < CNT_W'(MAX_INFLIGHT));
    accept = IN_VALID && IN_READY;
    alloc  = '0;
    found  = 1'b0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (!found && (!act[i] || ret[i])) begin
        alloc[i] = accept;
        found    = 1'b1;
      end
    end
    cool_d = cool_q;
    if (SOFT_CLR)            cool_d = '0;
    else if (accept)         cool_d = COOL_W'(FRAME_LEN - 1);
    else if (cool_q != '0)   cool_d = cool_q - COOL_W'(1);
    rdy_en_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cool_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      cool_q   <= cool_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  always_comb begin
    STG_START = '0;
    OUT_VALID = 1'b0;
    OUT_FIRST = 1'b0;
    OUT_LAST  = 1'b0;
    OUT_TAG   = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      STG_START = STG_START | so[i].stg;
      OUT_VALID = OUT_VALID | so[i].ov;
      OUT_FIRST = OUT_FIRST | so[i].first;
      OUT_LAST  = OUT_LAST  | so[i].last;
      OUT_TAG   = OUT_TAG   | so[i].tag;
    end
  end

  assign INFLIGHT = n_act;
  assign BUSY     = (n_act != '0);

  // frame spacing keeps each stage pulse owned by a single slot
  always_comb begin
    stg_multi = '0;
    for (int k = 0; k < NUM_STG; k++)
      for (int i = 0; i < MAX_INFLIGHT; i++)
        for (int j = i + 1; j < MAX_INFLIGHT; j++)
          if (so[i].stg[k] && so[j].stg[k]) stg_multi[k] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) assert (stg_multi == '0) else $error("stage start owned by two frames");
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed checks of fft_frame_sequencer: a default instance and a 2-slot instance share stimulus.
module tb_fft_frame_sequencer;
  logic CLK = 1'b0, RST = 1'b0, in_valid = 1'b0, soft_clr = 1'b0;
  logic [2:0] in_tag = '0;
  logic rdy1, ov1, f1, l1, busy1, rdy2, ov2, f2, l2, busy2;
  logic [4:0] stg1, stg2;
  logic [2:0] tag1, tag2, inf1, inf2;
  int total = 0, bad = 0;
  int ofs[5] = '{3, 7, 17, 21, 26};

  always #5 CLK = ~CLK;

  fft_frame_sequencer u_dut (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_TAG(in_tag), .IN_READY(rdy1),
    .SOFT_CLR(soft_clr), .STG_START(stg1), .OUT_VALID(ov1), .OUT_FIRST(f1),
    .OUT_LAST(l1), .OUT_TAG(tag1), .INFLIGHT(inf1), .BUSY(busy1));

  fft_frame_sequencer #(.MAX_INFLIGHT(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_TAG(in_tag), .IN_READY(rdy2),
    .SOFT_CLR(soft_clr), .STG_START(stg2), .OUT_VALID(ov2), .OUT_FIRST(f2),
    .OUT_LAST(l2), .OUT_TAG(tag2), .INFLIGHT(inf2), .BUSY(busy2));

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] t, input logic sc);
    @(negedge CLK);
    in_valid = v;
    in_tag   = t;
    soft_clr = sc;
    #1;
  endtask

  initial begin
    int es, eov, ef, el, etag, einf, erdy, n;
    logic [2:0] nt;
    logic [2:0] qtag[$];

    // reset state
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ready", 32'(rdy1), 0);
    chk("rst_inflight", 32'(inf1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_outs", 32'({stg1, ov1, f1, l1, tag1}), 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rel_ready_early", 32'(rdy1), 0);
    step(0, 0, 0);
    chk("rel_ready", 32'(rdy1), 1);
    chk("rel_ready2", 32'(rdy2), 1);

    // single frame, tag 5
    for (int c = 0; c <= 40; c++) begin
      step(c == 0, 3'd5, 0);
      es = 0;
      for (int k = 0; k < 5; k++) if (c == ofs[k]) es |= (1 << k);
      eov = (c >= 30 && c <= 37) ? 1 : 0;
      chk($sformatf("t1_stg@%0d", c), 32'(stg1), es);
      chk($sformatf("t1_ov@%0d", c), 32'(ov1), eov);
      chk($sformatf("t1_first@%0d", c), 32'(f1), (c == 30) ? 1 : 0);
      chk($sformatf("t1_last@%0d", c), 32'(l1), (c == 37) ? 1 : 0);
      chk($sformatf("t1_tag@%0d", c), 32'(tag1), eov ? 5 : 0);
      chk($sformatf("t1_inf@%0d", c), 32'(inf1), (c >= 1 && c <= 37) ? 1 : 0);
      chk($sformatf("t1_busy@%0d", c), 32'(busy1), (c >= 1 && c <= 37) ? 1 : 0);
      if (c == 0) chk("t1_ready0", 32'(rdy1), 1);
    end

    // IN_VALID held high; tag of accept n is n+1
    for (int c = 0; c <= 72; c++) begin
      step(1, 3'((c / 8 + 1) % 8), 0);
      es = 0; einf = 0;
      for (int a = 0; a < c; a += 8) begin
        if (c <= a + 37) einf++;
        for (int k = 0; k < 5; k++) if (c - a == ofs[k]) es |= (1 << k);
      end
      chk($sformatf("t2_ready@%0d", c), 32'(rdy1), (c % 8 == 0) ? 1 : 0);
      chk($sformatf("t2_inf@%0d", c), 32'(inf1), einf);
      chk($sformatf("t2_stg@%0d", c), 32'(stg1), es);
      chk($sformatf("t2_ov@%0d", c), 32'(ov1), (c >= 30) ? 1 : 0);
      chk($sformatf("t2_first@%0d", c), 32'(f1), (c >= 30 && (c - 30) % 8 == 0) ? 1 : 0);
      chk($sformatf("t2_last@%0d", c), 32'(l1), (c >= 37 && (c - 37) % 8 == 0) ? 1 : 0);
      chk($sformatf("t2_tag@%0d", c), 32'(tag1), (c >= 30) ? ((c - 30) / 8 + 1) % 8 : 0);
      // two-slot instance: accepts at 0, 8, 37 (reuses the retiring slot), 45
      erdy = (c == 0 || c == 8 || c == 37 || c == 45) ? 1 : 0;
      eov  = ((c >= 30 && c <= 45) || c >= 67) ? 1 : 0;
      etag = (c >= 30 && c <= 37) ? 1 : (c >= 38 && c <= 45) ? 2 : (c >= 67) ? 5 : 0;
      chk($sformatf("t2b_ready@%0d", c), 32'(rdy2), erdy);
      chk($sformatf("t2b_inf@%0d", c), 32'(inf2), (c == 0) ? 0 : (c <= 8) ? 1 : 2);
      chk($sformatf("t2b_ov@%0d", c), 32'(ov2), eov);
      chk($sformatf("t2b_first@%0d", c), 32'(f2), (c == 30 || c == 38 || c == 67) ? 1 : 0);
      chk($sformatf("t2b_last@%0d", c), 32'(l2), (c == 37 || c == 45) ? 1 : 0);
      chk($sformatf("t2b_tag@%0d", c), 32'(tag2), etag);
    end
    step(1, 0, 1);
    chk("flush_ready_clr", 32'(rdy1), 0);
    step(0, 0, 0);
    chk("flush_inf", 32'(inf1), 0);
    chk("flush_inf2", 32'(inf2), 0);
    chk("flush_busy", 32'(busy1), 0);
    chk("flush_ready", 32'(rdy1), 1);

    // SOFT_CLR at cycle 20 with frames at 0 and 8
    for (int c = 0; c <= 40; c++) begin
      step(c == 0 || c == 8 || c == 20, (c < 8) ? 3'd3 : 3'd4, c == 20);
      es = (c == 3 || c == 11) ? 1 : (c == 7 || c == 15) ? 2 : (c == 17) ? 4 : 0;
      erdy = (c == 0 || c == 8 || (c >= 16 && c != 20)) ? 1 : 0;
      einf = (c >= 1 && c <= 8) ? 1 : (c >= 9 && c <= 20) ? 2 : 0;
      chk($sformatf("t3_stg@%0d", c), 32'(stg1), es);
      chk($sformatf("t3_ready@%0d", c), 32'(rdy1), erdy);
      chk($sformatf("t3_inf@%0d", c), 32'(inf1), einf);
      chk($sformatf("t3_inf2@%0d", c), 32'(inf2), einf);
      chk($sformatf("t3_ov@%0d", c), 32'(ov1), 0);
    end

    // asynchronous reset mid-frame
    for (int c = 0; c <= 11; c++) step(c == 0, 3'd6, 0);
    @(negedge CLK);
    #1;
    chk("t4_inf_pre", 32'(inf1), 1);
    #2;
    RST = 1'b0;
    #1;
    chk("t4_ready_rst", 32'(rdy1), 0);
    chk("t4_inf_rst", 32'(inf1), 0);
    chk("t4_busy_rst", 32'(busy1), 0);
    chk("t4_outs_rst", 32'({stg1, ov1, f1, l1, tag1}), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("t4_ready_rel_early", 32'(rdy1), 0);
    step(0, 0, 0);
    chk("t4_ready_rel", 32'(rdy1), 1);
    for (int c = 0; c < 40; c++) begin
      step(0, 0, 0);
      chk($sformatf("t4_quiet@%0d", c), 32'({stg1, ov1, inf1}), 0);
    end

    // random IN_VALID: output tag order must follow accept order
    nt = 3'd0;
    n = 0;
    for (int c = 0; c < 345; c++) begin
      step((c < 300) && ($urandom_range(0, 3) == 0), nt, 0);
      if (f1) begin
        n++;
        if (qtag.size() == 0) chk($sformatf("rnd_first_unexpected@%0d", c), 1, 0);
        else chk($sformatf("rnd_tag@%0d", c), 32'(tag1), 32'(qtag.pop_front()));
      end
      if (in_valid && rdy1) begin
        qtag.push_back(nt);
        nt = nt + 3'd1;
      end
    end
    chk("rnd_drained", qtag.size(), 0);
    chk("rnd_inf_end", 32'(inf1), 0);
    chk("rnd_some_frames", (n > 5) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
